// File: rtl/datamemory_sized_if.sv
// Request/response bus of the sized data memory: one request per accepted cycle,
// load data returned on a one-cycle valid strobe, misalignment reported on err.
interface datamemory_sized_if #(
    parameter int ADDRESS_SZ = 12,
    parameter int DATA_SZ    = 32
);
    logic                  req;
    logic                  we;
    logic [1:0]            size;
    logic                  sign_ext;
    logic [ADDRESS_SZ-1:0] address;
    logic [DATA_SZ-1:0]    data_in;
    logic                  ready;
    logic                  valid;
    logic [DATA_SZ-1:0]    data_out;
    logic                  err;

    modport master (
        output req, we, size, sign_ext, address, data_in,
        input  ready, valid, data_out, err
    );

    modport slave (
        input  req, we, size, sign_ext, address, data_in,
        output ready, valid, data_out, err
    );
endinterface

// File: rtl/datamemory_sized.sv
// Byte/half/word data memory with a zeroing sweep after reset and 2-edge loads.
// Define DATAMEMORY_SIZED_ALIGN_TRAP_EN to trap misaligned accesses on err instead of forcing alignment.
module datamemory_sized #(
    parameter int ADDRESS_SZ = 12,
    parameter int DATA_SZ    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    datamemory_sized_if.slave   bus
);
    localparam int WORD_AW = ADDRESS_SZ - 2;
    localparam int DEPTH   = 1 << WORD_AW;
    localparam logic [WORD_AW-1:0] LAST_WORD = {WORD_AW{1'b1}};

    typedef enum logic [1:0] {INIT, IDLE, RD} state_t;

    state_t               state, state_next;
    logic [WORD_AW-1:0]   init_cnt;
    logic [31:0]          mem [DEPTH];

    logic                 accept;
    logic                 load_accept;
    logic                 store_accept;
    logic                 trap;
    logic [1:0]           eff_size;
    logic [1:0]           eff_off;
    logic [3:0]           lane_en;
    logic [31:0]          store_data;

    logic [3:0]           mem_we;
    logic [WORD_AW-1:0]   mem_widx;
    logic [31:0]          mem_wdata;

    logic [31:0]          rd_word;
    logic [1:0]           rd_size;
    logic [1:0]           rd_off;
    logic                 rd_sign;
    logic [31:0]          shifted;
    logic [31:0]          load_data;

    logic                 valid_q;
    logic [31:0]          data_out_q;

    assign accept       = bus.req && (state == IDLE);
    assign load_accept  = accept && !bus.we && !trap;
    assign store_accept = accept &&  bus.we && !trap;

    // Either flag a misaligned request, or fold it onto the aligned lanes it overlaps.
    always_comb begin
        eff_size = bus.size;
        eff_off  = bus.address[1:0];
        trap     = 1'b0;
`ifdef DATAMEMORY_SIZED_ALIGN_TRAP_EN
        case (bus.size)
            2'b00:   trap = 1'b0;
            2'b01:   trap = bus.address[0];
            2'b10:   trap = (bus.address[1:0] != 2'b00);
            default: trap = 1'b1;
        endcase
`else
        if (bus.size == 2'b11) begin
            eff_size = 2'b10;
        end
        case (eff_size)
            2'b01:   eff_off = {bus.address[1], 1'b0};
            2'b10:   eff_off = 2'b00;
            default: eff_off = bus.address[1:0];
        endcase
`endif
    end

    always_comb begin
        case (eff_size)
            2'b00: begin
                lane_en    = 4'b0001 << eff_off;
                store_data = {4{bus.data_in[7:0]}};
            end
            2'b01: begin
                lane_en    = 4'b0011 << eff_off;
                store_data = {2{bus.data_in[15:0]}};
            end
            default: begin
                lane_en    = 4'b1111;
                store_data = bus.data_in;
            end
        endcase
    end

    // The sweep owns the write port during INIT; stores only ever happen in IDLE.
    always_comb begin
        mem_we    = 4'b0000;
        mem_widx  = '0;
        mem_wdata = '0;
        if (state == INIT) begin
            mem_we    = 4'b1111;
            mem_widx  = init_cnt;
            mem_wdata = '0;
        end else if (store_accept) begin
            mem_we    = lane_en;
            mem_widx  = bus.address[ADDRESS_SZ-1:2];
            mem_wdata = store_data;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we[i]) begin
                mem[mem_widx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
        if (load_accept) begin
            rd_word <= mem[bus.address[ADDRESS_SZ-1:2]];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (init_cnt == LAST_WORD) state_next = IDLE;
            IDLE:    if (load_accept)           state_next = RD;
            RD:      state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        shifted = rd_word >> {rd_off, 3'b000};
        case (rd_size)
            2'b00:   load_data = {{24{rd_sign & shifted[7]}},  shifted[7:0]};
            2'b01:   load_data = {{16{rd_sign & shifted[15]}}, shifted[15:0]};
            default: load_data = rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            init_cnt   <= '0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
            rd_size    <= 2'b00;
            rd_off     <= 2'b00;
            rd_sign    <= 1'b0;
        end else begin
            state   <= state_next;
            valid_q <= (state == RD);
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (state == RD) begin
                data_out_q <= load_data;
            end
            if (load_accept) begin
                rd_size <= eff_size;
                rd_off  <= eff_off;
                rd_sign <= bus.sign_ext;
            end
        end
    end

`ifdef DATAMEMORY_SIZED_ALIGN_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && trap;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.ready    = (state == IDLE);
    assign bus.valid    = valid_q;
    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_datamemory_sized.sv
// Self-checking bench for datamemory_sized: directed scenarios plus random traffic
// compared against a byte-array model of the memory.
module tb_datamemory_sized;
    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int DEPTH  = 1 << (AW - 2);
    localparam int NBYTES = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;

    datamemory_sized_if #(.ADDRESS_SZ(AW), .DATA_SZ(DW)) bus ();

    datamemory_sized #(.ADDRESS_SZ(AW), .DATA_SZ(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [7:0] model_mem [NBYTES];

    function automatic int unsigned size_bytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;
    endfunction

    function automatic void model_store(input int unsigned a, input logic [1:0] sz, input logic [31:0] d);
        int unsigned n    = size_bytes(sz);
        int unsigned base = a - (a % n);
        for (int i = 0; i < int'(n); i++) model_mem[base + i] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] model_load(input int unsigned a, input logic [1:0] sz, input logic sx);
        int unsigned n    = size_bytes(sz);
        int unsigned base = a - (a % n);
        logic [31:0] v    = 32'h0;
        for (int i = 0; i < int'(n); i++) v = v | (32'(model_mem[base + i]) << (8*i));
        if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.ready !== 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.ready !== 1'b1) begin
            checks++;
            fails++;
            $display("[TB] FAIL ready_timeout got ready=%b want 1 within 3000 cycles", bus.ready);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input int unsigned a, input logic [31:0] d);
        wait_ready();
        bus.req      = 1'b1;
        bus.we       = w;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.address  = AW'(a);
        bus.data_in  = d;
        @(posedge clk); #1;
        bus.req = 1'b0;
    endtask

    task automatic do_load(input int unsigned a, input logic [1:0] sz, input logic sx,
                           output logic [31:0] d, output int lat);
        issue(1'b0, sz, sx, a, 32'h0);
        lat = 0;
        while (bus.valid !== 1'b1 && lat < 4) begin
            @(posedge clk); #1;
            lat++;
        end
        d = bus.data_out;
    endtask

    task automatic count_init(output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (bus.ready !== 1'b1 && n < DEPTH + 16) begin
            if (bus.valid === 1'b1) saw_valid = 1'b1;
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int lat, n;
        bit sv;
        rst_n = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.address = '0; bus.data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready got %b want 0", bus.ready); end
        checks++; if (bus.valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b want 0", bus.valid); end
        checks++; if (bus.err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err got %b want 0", bus.err); end
        checks++; if (bus.data_out !== 32'h0) begin fails++; $display("[TB] FAIL reset_data_out got %h want 0", bus.data_out); end
        rst_n = 1'b1;
        count_init(n, sv);
        checks++; if (n != DEPTH) begin fails++; $display("[TB] FAIL init_length got %0d want %0d", n, DEPTH); end
        model_clear();
        do_load(32'h0FC, 2'b10, 1'b0, d, lat);
        checks++; if (lat != 1) begin fails++; $display("[TB] FAIL init_load_latency got %0d want 1", lat); end
        checks++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL init_load_0FC got %h want 00000000", d); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        logic [31:0] exp_s [4];
        int lat;
        exp_s[0] = 32'h0000_0001; exp_s[1] = 32'h0000_007F;
        exp_s[2] = 32'hFFFF_FFFF; exp_s[3] = 32'hFFFF_FF80;
        issue(1'b1, 2'b10, 1'b0, 32'h010, 32'h80FF_7F01);
        model_store(32'h010, 2'b10, 32'h80FF_7F01);
        for (int i = 0; i < 4; i++) begin
            do_load(32'h010 + i, 2'b00, 1'b1, d, lat);
            checks++; if (d !== exp_s[i]) begin fails++; $display("[TB] FAIL byte_load_signed_%0d got %h want %h", i, d, exp_s[i]); end
        end
        do_load(32'h013, 2'b00, 1'b0, d, lat);
        checks++; if (d !== 32'h0000_0080) begin fails++; $display("[TB] FAIL byte_load_unsigned got %h want 00000080", d); end
    endtask

    task automatic test_halfword();
        logic [31:0] d;
        int lat;
        issue(1'b1, 2'b10, 1'b0, 32'h020, 32'h1122_3344);
        issue(1'b1, 2'b01, 1'b0, 32'h022, 32'h0000_BEEF);
        model_store(32'h020, 2'b10, 32'h1122_3344);
        model_store(32'h022, 2'b01, 32'h0000_BEEF);
        do_load(32'h020, 2'b10, 1'b1, d, lat);
        checks++; if (d !== 32'hBEEF_3344) begin fails++; $display("[TB] FAIL half_store_word got %h want BEEF3344", d); end
        do_load(32'h022, 2'b01, 1'b1, d, lat);
        checks++; if (d !== 32'hFFFF_BEEF) begin fails++; $display("[TB] FAIL half_load_signed got %h want FFFFBEEF", d); end
        do_load(32'h020, 2'b01, 1'b1, d, lat);
        checks++; if (d !== 32'h0000_3344) begin fails++; $display("[TB] FAIL half_load_low got %h want 00003344", d); end
    endtask

    task automatic test_store_then_load();
        logic [31:0] d, w;
        int unsigned a;
        int lat;
        for (int k = 0; k < 4; k++) begin
            a = ($urandom_range(0, DEPTH - 1)) * 4;
            w = $urandom;
            issue(1'b1, 2'b10, 1'b0, a, w);
            model_store(a, 2'b10, w);
            do_load(a, 2'b10, 1'b0, d, lat);
            checks++; if (d !== w) begin fails++; $display("[TB] FAIL store_then_load_%0d got %h want %h", k, d, w); end
            checks++; if (lat != 1) begin fails++; $display("[TB] FAIL store_then_load_latency_%0d got %0d want 1", k, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int pulses = 0;
        w = $urandom;
        issue(1'b1, 2'b10, 1'b0, 32'h040, w);
        model_store(32'h040, 2'b10, w);
        wait_ready();
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0; bus.address = AW'(32'h040);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            checks++; if (bus.ready !== 1'(c % 2)) begin fails++; $display("[TB] FAIL b2b_ready_%0d got %b want %0d", c, bus.ready, c % 2); end
            checks++; if (bus.valid !== 1'(c % 2)) begin fails++; $display("[TB] FAIL b2b_valid_%0d got %b want %0d", c, bus.valid, c % 2); end
            if (bus.valid === 1'b1) begin
                pulses++;
                checks++; if (bus.data_out !== w) begin fails++; $display("[TB] FAIL b2b_data_%0d got %h want %h", c, bus.data_out, w); end
            end
        end
        bus.req = 1'b0;
        checks++; if (pulses != 4) begin fails++; $display("[TB] FAIL b2b_pulses got %0d want 4", pulses); end
    endtask

    task automatic test_misaligned();
        logic [31:0] d;
        int lat;
        issue(1'b1, 2'b10, 1'b0, 32'h030, 32'h1111_1111);
        model_store(32'h030, 2'b10, 32'h1111_1111);
        issue(1'b1, 2'b10, 1'b0, 32'h031, 32'hCAFE_F00D);
`ifdef DATAMEMORY_SIZED_ALIGN_TRAP_EN
        checks++; if (bus.err !== 1'b1) begin fails++; $display("[TB] FAIL mis_store_err got %b want 1", bus.err); end
        @(posedge clk); #1;
        checks++; if (bus.err !== 1'b0) begin fails++; $display("[TB] FAIL mis_store_err_width got %b want 0", bus.err); end
        do_load(32'h030, 2'b10, 1'b0, d, lat);
        checks++; if (d !== 32'h1111_1111) begin fails++; $display("[TB] FAIL mis_store_kept got %h want 11111111", d); end
        issue(1'b0, 2'b01, 1'b1, 32'h023, 32'h0);
        checks++; if (bus.err !== 1'b1) begin fails++; $display("[TB] FAIL mis_load_err got %b want 1", bus.err); end
        @(posedge clk); #1;
        checks++; if (bus.valid !== 1'b0) begin fails++; $display("[TB] FAIL mis_load_valid got %b want 0", bus.valid); end
        checks++; if (bus.ready !== 1'b1) begin fails++; $display("[TB] FAIL mis_load_ready got %b want 1", bus.ready); end
`else
        model_store(32'h031, 2'b10, 32'hCAFE_F00D);
        checks++; if (bus.err !== 1'b0) begin fails++; $display("[TB] FAIL mis_store_err got %b want 0", bus.err); end
        @(posedge clk); #1;
        checks++; if (bus.err !== 1'b0) begin fails++; $display("[TB] FAIL mis_store_err_late got %b want 0", bus.err); end
        do_load(32'h030, 2'b10, 1'b0, d, lat);
        checks++; if (d !== 32'hCAFE_F00D) begin fails++; $display("[TB] FAIL mis_store_aligned got %h want CAFEF00D", d); end
        do_load(32'h023, 2'b01, 1'b1, d, lat);
        checks++; if (d !== model_load(32'h023, 2'b01, 1'b1)) begin fails++; $display("[TB] FAIL mis_half_load got %h want %h", d, model_load(32'h023, 2'b01, 1'b1)); end
        do_load(32'h032, 2'b11, 1'b1, d, lat);
        checks++; if (d !== 32'hCAFE_F00D) begin fails++; $display("[TB] FAIL size3_as_word got %h want CAFEF00D", d); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] d, exp, w;
        logic [1:0] sz;
        logic sx, wr;
        int unsigned a;
        int lat;
        for (int k = 0; k < 300; k++) begin
            wr = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            w  = $urandom;
            a  = $urandom_range(0, NBYTES - 1);
`ifdef DATAMEMORY_SIZED_ALIGN_TRAP_EN
            sz = 2'($urandom_range(0, 2));
            a  = a - (a % size_bytes(sz));
`else
            sz = 2'($urandom_range(0, 3));
`endif
            if (wr) begin
                issue(1'b1, sz, sx, a, w);
                model_store(a, sz, w);
            end else begin
                exp = model_load(a, sz, sx);
                do_load(a, sz, sx, d, lat);
                checks++; if (d !== exp || lat != 1) begin
                    fails++;
                    $display("[TB] FAIL rand_load_%0d addr=%h size=%0d sx=%b got %h lat %0d want %h lat 1", k, a, sz, sx, d, lat, exp);
                end
            end
        end
    endtask

    task automatic test_reset_in_rd();
        logic [31:0] d;
        int lat, n;
        bit sv;
        issue(1'b1, 2'b10, 1'b0, 32'h050, 32'hA5A5_5A5A);
        issue(1'b1, 2'b10, 1'b0, 32'h000, 32'h1234_5678);
        issue(1'b0, 2'b10, 1'b0, 32'h050, 32'h0);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.valid !== 1'b0) begin fails++; $display("[TB] FAIL rd_reset_valid got %b want 0", bus.valid); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.valid !== 1'b0 || bus.ready !== 1'b0) begin
            fails++; $display("[TB] FAIL rd_reset_hold got valid=%b ready=%b want 0 0", bus.valid, bus.ready);
        end
        rst_n = 1'b1;
        count_init(n, sv);
        checks++; if (n != DEPTH) begin fails++; $display("[TB] FAIL rd_reset_init_length got %0d want %0d", n, DEPTH); end
        checks++; if (sv) begin fails++; $display("[TB] FAIL rd_reset_stray_valid got 1 want 0"); end
        model_clear();
        do_load(32'h000, 2'b10, 1'b0, d, lat);
        checks++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL rd_reset_word0 got %h want 00000000", d); end
        do_load(32'h050, 2'b10, 1'b0, d, lat);
        checks++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL rd_reset_word50 got %h want 00000000", d); end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_halfword();
        test_store_then_load();
        test_back_to_back();
        test_misaligned();
        test_random();
        test_reset_in_rd();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/datamemory_sized.md
DATAMEMORY_SIZED -- requirements
Module: datamemory_sized

Interface
REQ-001 Parameter ADDRESS_SZ, default 12: byte-address width; the array SHALL hold DEPTH = 2^(ADDRESS_SZ-2) words.
REQ-002 Parameter DATA_SZ, default 32: word width; the only legal value SHALL be 32, with four byte lanes.
REQ-003 Port clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port req  input  1: access request.
REQ-006 Port we  input  1: 1 = store, 0 = load.
REQ-007 Port size  input  2: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 Port sign_ext  input  1: for loads, 1 = sign-extend, 0 = zero-extend.
REQ-009 Port address  input  ADDRESS_SZ: byte address.
REQ-010 Port data_in  input  DATA_SZ: store data, right-aligned.
REQ-011 Port ready  output  1: block can accept a request this cycle.
REQ-012 Port valid  output  1: one-cycle load-response strobe.
REQ-013 Port data_out  output  DATA_SZ: load data, right-aligned and extended.
REQ-014 Port err  output  1: one-cycle misalignment/illegal-size strobe.

Function
REQ-015 A request SHALL be accepted at a rising edge where req=1 and ready=1; inputs SHALL be ignored otherwise.
REQ-016 FSM states SHALL be INIT, IDLE and RD; ready SHALL be 1 only in IDLE.
REQ-017 INIT SHALL write zero to one word per cycle, word index 0..DEPTH-1, using an internal counter.
REQ-018 INIT SHALL move to IDLE on the edge that writes word DEPTH-1; INIT therefore lasts exactly DEPTH cycles.
REQ-019 An accepted store SHALL write only the addressed lanes in that same edge.
REQ-020 Store lanes: byte = lane address[1:0]; half = lanes {address[1],0} and +1; word = all lanes.
REQ-021 Store data SHALL come from data_in[7:0], [15:0] or [31:0] respectively, and the FSM SHALL stay in IDLE, giving one store per cycle.
REQ-022 An accepted load SHALL read word address[ADDRESS_SZ-1:2] synchronously and move the FSM to RD.
REQ-023 On the next edge the FSM SHALL return to IDLE, register data_out and pulse valid high for exactly one cycle.
REQ-024 Load latency SHALL be 2 edges from acceptance to valid; maximum load throughput is one per 2 cycles.
REQ-025 data_out SHALL hold its value until the next load response.
REQ-026 Load extraction SHALL select the byte or half by address bits and extend it to 32 bits per sign_ext; a word load SHALL ignore sign_ext.
REQ-027 A load issued on the cycle after a store to the same word SHALL return the newly stored data.
REQ-028 Misaligned accesses are: half with address[0]=1; word with address[1:0]!=0; any size=11 (handling per REQ-033/034).

Reset
REQ-029 While rst_n=0: ready=0, valid=0, err=0, data_out=0, FSM=INIT, INIT counter=0.
REQ-030 Reset asserted mid-INIT SHALL restart the sweep at word 0 after release.
REQ-031 Reset asserted in RD SHALL discard the pending load; no valid SHALL follow.
REQ-032 Array contents SHALL NOT be reset asynchronously; zeroing SHALL be done only by INIT.

Configuration
REQ-033 With macro DATAMEMORY_SIZED_ALIGN_TRAP_EN defined, a misaligned access SHALL be accepted, SHALL NOT write the array, SHALL NOT enter RD, and SHALL pulse err for one cycle after acceptance; valid SHALL stay 0.
REQ-034 Without the macro, err SHALL be tied to 0; the address low bits SHALL be forced to alignment (half: bit0=0; word: bits[1:0]=0); size=11 SHALL be treated as word.

Verification
REQ-035 Reset release -> ready=0 for exactly 1024 cycles (ADDRESS_SZ=12); a load of 0x0FC then returns 0x00000000.
REQ-036 Word store 0x80FF7F01 at 0x010, then byte loads at 0x010..0x013 with sign_ext=1 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; with sign_ext=0, the last returns 0x00000080.
REQ-037 Half store 0xBEEF at 0x022 over word 0x11223344 -> word load of 0x020 returns 0xBEEF3344; half load of 0x022 with sign_ext=1 returns 0xFFFFBEEF.
REQ-038 Load request held high continuously -> valid pulses every 2nd cycle and ready toggles 1,0,1,0.
REQ-039 With the macro: word store at 0x031 -> err pulses 1 cycle, word 0x030 unchanged. Without the macro: the same store writes word 0x030, err=0.
REQ-040 rst_n pulsed low while in RD -> no valid pulse; INIT sweep restarts from word 0.
